// File: rtl/stage1_pkg.sv
// Shared types and widths for the Stage1 round controller and its op-select mux.
package stage1_pkg;

   localparam int BLOCK_W = 128;
   localparam int BYTE_W  = 8;

   // Stage1 op select, encoded as {k9,k8}
   typedef enum logic [1:0] {
      OP_INV  = 2'b00,
      OP_ROR2 = 2'b01,
      OP_ROL2 = 2'b10,
      OP_HINV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } ctrl_state_e;

endpackage

// File: rtl/stage1_op_sel.sv
// Selects the current round's 2-bit op from the latched key register.
module stage1_op_sel
   import stage1_pkg::*;
#(
   parameter int MAX_ROUNDS = 8,
   parameter int RND_W      = $clog2(MAX_ROUNDS + 1)
) (
   input  logic [2*MAX_ROUNDS-1:0] key,
   input  logic [RND_W-1:0]        cnt,
   output op_e                     op
);

   always_comb begin
      op = OP_INV;
      for (int i = 0; i < MAX_ROUNDS; i++) begin
         if (cnt == RND_W'(i)) op = op_e'(key[2*i +: 2]);
      end
   end

endmodule

// File: rtl/stage1_round_ctrl.sv
// Sequences one 128-bit block through N rounds of the external Stage1 transform.
//
// state | meaning
// IDLE  | ready for a block; in_ready high
// RUN   | one Stage1 round per clock, result fed back into the data register
// DONE  | result presented on out_block until out_ready
module stage1_round_ctrl
   import stage1_pkg::*;
#(
   parameter int MAX_ROUNDS = 8,
   parameter int RND_W      = $clog2(MAX_ROUNDS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    abort,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BLOCK_W-1:0]      in_block,
   input  logic [2*MAX_ROUNDS-1:0] in_key,
   input  logic [RND_W-1:0]        in_rounds,
   output logic                    stg_en,
   output logic                    stg_k9,
   output logic                    stg_k8,
   output logic [BLOCK_W-1:0]      stg_din,
   input  logic [BLOCK_W-1:0]      stg_dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BLOCK_W-1:0]      out_block,
   output logic                    busy,
   output logic [15:0]             blk_cnt
);

   ctrl_state_e             state_q, state_d;
   logic [BLOCK_W-1:0]      data_q;
   logic [2*MAX_ROUNDS-1:0] key_q;
   logic [RND_W-1:0]        rnds_q, cnt_q, rnds_in;
   logic [15:0]             blk_cnt_q;
   logic                    accept, out_fire;
   op_e                     op;

   assign rnds_in = (in_rounds > RND_W'(MAX_ROUNDS)) ? RND_W'(MAX_ROUNDS) : in_rounds;

   stage1_op_sel #(
      .MAX_ROUNDS (MAX_ROUNDS),
      .RND_W      (RND_W)
   ) u_op_sel (
      .key (key_q),
      .cnt (cnt_q),
      .op  (op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // k9/k8 decode only registered key/cnt/state, so they never follow in_*
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      stg_en    = 1'b0;
      stg_k9    = 1'b0;
      stg_k8    = 1'b0;
      stg_din   = '0;
      out_block = '0;
      accept    = 1'b0;
      out_fire  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !abort) begin
               accept  = 1'b1;
               state_d = (rnds_in == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            stg_en  = 1'b1;
            stg_k9  = op[1];
            stg_k8  = op[0];
            stg_din = data_q;
            if (abort)                              state_d = IDLE;
            else if (cnt_q == rnds_q - RND_W'(1))   state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            out_block = data_q;
            if (out_ready) begin
               out_fire = 1'b1;
               state_d  = IDLE;
            end else if (abort) begin
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '0;
         key_q     <= '0;
         rnds_q    <= '0;
         cnt_q     <= '0;
         blk_cnt_q <= '0;
      end else begin
         if (accept) begin
            data_q <= in_block;
            key_q  <= in_key;
            rnds_q <= rnds_in;
            cnt_q  <= '0;
         end else if (state_q == RUN) begin
            data_q <= stg_dout;
            cnt_q  <= cnt_q + RND_W'(1);
         end
         if (out_fire) blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign busy    = (state_q != IDLE);
   assign blk_cnt = blk_cnt_q;

endmodule

// File: tb/tb_stage1_round_ctrl.sv
// Scoreboard bench for stage1_round_ctrl with a behavioural Stage1 byte transform.
module tb_stage1_round_ctrl;
   import stage1_pkg::*;

   localparam int MAX_ROUNDS = 8;
   localparam int RND_W      = $clog2(MAX_ROUNDS + 1);

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    abort = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [127:0]            in_block = '0;
   logic [2*MAX_ROUNDS-1:0] in_key = '0;
   logic [RND_W-1:0]        in_rounds = '0;
   logic                    stg_en, stg_k9, stg_k8;
   logic [127:0]            stg_din, stg_dout;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [127:0]            out_block;
   logic                    busy;
   logic [15:0]             blk_cnt;

   stage1_round_ctrl #(.MAX_ROUNDS(MAX_ROUNDS), .RND_W(RND_W)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
      .in_key(in_key), .in_rounds(in_rounds),
      .stg_en(stg_en), .stg_k9(stg_k9), .stg_k8(stg_k8),
      .stg_din(stg_din), .stg_dout(stg_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
      .busy(busy), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] s1_byte(input logic [7:0] b, input logic [1:0] op);
      case (op)
         2'b00:   return ~b;
         2'b01:   return {b[1:0], b[7:2]};
         2'b10:   return {b[5:0], b[7:6]};
         default: return b ^ 8'h0F;
      endcase
   endfunction

   function automatic logic [127:0] s1_block(input logic [127:0] d, input logic [1:0] op);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = s1_byte(d[8*i +: 8], op);
      return r;
   endfunction

   always_comb stg_dout = stg_en ? s1_block(stg_din, {stg_k9, stg_k8}) : '0;

   typedef struct {
      logic [127:0] blk;
      int           runs;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_cnt = '0;
   int          run_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts Stage1-enabled cycles per block and checks each output handshake
   always @(negedge clk) begin
      if (!rst_n || !busy) run_cnt = 0;
      else if (stg_en)     run_cnt++;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 128'd1, 128'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_block", out_block, e.blk);
            check("sb_runs", 128'(run_cnt), 128'(e.runs));
         end
      end
   end

   task automatic accept_blk(input logic [127:0] blk, input logic [15:0] key, input logic [3:0] rnds);
      int t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!in_ready) check("accept_timeout", 128'd0, 128'd1);
      in_block = blk; in_key = key; in_rounds = rnds; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int exp_lat);
      int lat = 1;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      check("latency", 128'(lat), 128'(exp_lat));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 100) begin @(posedge clk); #1; t++; end
      check("idle_timeout", 128'(busy), 128'd0);
      check("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
   endtask

   task automatic run_block(input logic [127:0] blk, input logic [15:0] key, input logic [3:0] rnds,
                            input logic [127:0] exp_blk, input int exp_runs, input int exp_lat);
      exp_t e;
      e.blk = exp_blk; e.runs = exp_runs;
      sb.push_back(e);
      exp_cnt++;
      accept_blk(blk, key, rnds);
      wait_valid(exp_lat);
      wait_idle();
   endtask

   localparam logic [127:0] B96  = {16{8'h96}};
   localparam logic [127:0] BRND = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit stable_v, stable_b, ready_lo, saw_valid;
      #1;
      check("rst_in_ready",  128'(in_ready),  128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy",      128'(busy),      128'd0);
      check("rst_stg",       128'({stg_en, stg_k9, stg_k8}), 128'd0);
      check("rst_blk_cnt",   128'(blk_cnt),   128'd0);
      check("rst_out_block", out_block,       128'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_block(B96, 16'h0000, 4'd1, {16{8'h69}}, 1, 2);
      run_block(B96, 16'h0001, 4'd1, {16{8'hA5}}, 1, 2);
      run_block(B96, 16'h0002, 4'd1, {16{8'h5A}}, 1, 2);
      run_block(B96, 16'h0003, 4'd1, {16{8'h99}}, 1, 2);
      // INV,ROR2,ROL2,HINV: the rotates cancel, leaving ~x ^ 0x0F = x ^ 0xF0
      run_block(BRND, 16'h00E4, 4'd4, BRND ^ {16{8'hF0}}, 4, 5);
      run_block(BRND, 16'hFFFF, 4'd0, BRND, 0, 1);
      // 11 rounds requested, clamped to 8 INV rounds -> unchanged
      run_block(BRND, 16'h0000, 4'd11, BRND, 8, 9);

      // Hold off downstream for 10 cycles in DONE
      out_ready = 1'b0;
      begin
         exp_t e;
         e.blk = {16{8'h69}}; e.runs = 1;
         sb.push_back(e);
      end
      accept_blk(B96, 16'h0000, 4'd1);
      wait_valid(2);
      stable_v = 1'b1; stable_b = 1'b1; ready_lo = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1)        stable_v = 1'b0;
         if (out_block !== {16{8'h69}}) stable_b = 1'b0;
         if (in_ready !== 1'b0)         ready_lo = 1'b0;
      end
      check("hold_valid", 128'(stable_v), 128'd1);
      check("hold_block", 128'(stable_b), 128'd1);
      check("hold_in_ready_low", 128'(ready_lo), 128'd1);
      out_ready = 1'b1;
      exp_cnt++;
      @(posedge clk); #1;
      check("release_idle", 128'(busy), 128'd0);
      check("release_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));

      // Abort beats a simultaneous accept in IDLE
      in_block = BRND; in_key = '0; in_rounds = 4'd2;
      in_valid = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; abort = 1'b0;
      check("idle_abort_not_taken", 128'(busy), 128'd0);

      // Abort during the second RUN cycle
      accept_blk(BRND, 16'h00E4, 4'd4);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", 128'(busy), 128'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) saw_valid = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_no_valid", 128'(saw_valid), 128'd0);
      check("abort_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));

      // Asynchronous reset in the middle of RUN
      accept_blk(BRND, 16'h0000, 4'd8);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",     128'(busy),      128'd0);
      check("arst_stg",      128'({stg_en, stg_k9, stg_k8}), 128'd0);
      check("arst_valid",    128'(out_valid), 128'd0);
      check("arst_in_ready", 128'(in_ready),  128'd1);
      check("arst_blk_cnt",  128'(blk_cnt),   128'd0);
      exp_cnt = '0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      // INV then HINV: ~x ^ 0x0F, 0x96 -> 0x66
      run_block(B96, 16'h000C, 4'd2, {16{8'h66}}, 2, 3);

      check("sb_empty", 128'(sb.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
